// File: rtl/ir_pkg.sv
// ============================================================================
//  Module   : ir_pkg
//  Purpose  : Shared widths, field offsets and decoded-field struct for the
//             instruction register queue.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ir_pkg;

    localparam int IR_INSTR_W = 16;
    localparam int IR_OPC_W   = 6;
    localparam int IR_VAL_W   = 8;

    localparam int IR_VAL_LSB = 0;
    localparam int IR_ACC_BIT = IR_VAL_W;
    localparam int IR_REG_BIT = IR_VAL_W + 1;
    localparam int IR_OPC_LSB = IR_VAL_W + 2;

    typedef struct packed {
        logic [IR_OPC_W-1:0] op_code;
        logic                reg_s;
        logic                acc_s;
        logic [IR_VAL_W-1:0] val;
    } ir_fields_t;

endpackage

`default_nettype wire

// File: rtl/ir_field_decode.sv
// ============================================================================
//  Module   : ir_field_decode
//  Purpose  : Combinational split of an instruction word into its fields, with
//             an optional opcode range check (macro IR_ILLEGAL_CHK_EN).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ir_field_decode
    import ir_pkg::*;
#(
    parameter int INSTR_W = IR_INSTR_W,
    parameter int OPC_W   = IR_OPC_W,
    parameter int VAL_W   = IR_VAL_W,
    parameter int NUM_OPS = 40
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic               valid,
    output ir_fields_t         fields,
    output logic               illegal
);

    localparam int ACC_BIT = VAL_W;
    localparam int REG_BIT = VAL_W + 1;
    localparam int OPC_LSB = VAL_W + 2;

    if (INSTR_W != OPC_W + 2 + VAL_W) begin : g_bad_instr_w
        $error("ir_field_decode: INSTR_W must equal OPC_W+2+VAL_W");
    end
    if (OPC_W > IR_OPC_W || VAL_W > IR_VAL_W) begin : g_bad_field_w
        $error("ir_field_decode: field widths exceed ir_fields_t");
    end
    if (NUM_OPS < 1 || NUM_OPS > (1 << OPC_W)) begin : g_bad_num_ops
        $error("ir_field_decode: NUM_OPS out of opcode range");
    end

    // Empty head presents an all-zero field set.
    always_comb begin
        fields = '0;
        if (valid) begin
            fields.op_code = IR_OPC_W'(instr[OPC_LSB +: OPC_W]);
            fields.reg_s   = instr[REG_BIT];
            fields.acc_s   = instr[ACC_BIT];
            fields.val     = IR_VAL_W'(instr[VAL_W-1:0]);
        end
    end

`ifdef IR_ILLEGAL_CHK_EN
    assign illegal = valid && (32'(instr[OPC_LSB +: OPC_W]) >= NUM_OPS);
`else
    assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_queue.sv
// ============================================================================
//  Module   : instr_queue
//  Purpose  : DEPTH-entry prefetch queue feeding a field-decoded instruction
//             register; optional opcode check under IR_ILLEGAL_CHK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_queue
    import ir_pkg::*;
#(
    parameter int INSTR_W = IR_INSTR_W,
    parameter int OPC_W   = IR_OPC_W,
    parameter int VAL_W   = IR_VAL_W,
    parameter int DEPTH   = 4,
    parameter int NUM_OPS = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPC_W-1:0]           op_code,
    output logic                       reg_s,
    output logic                       acc_s,
    output logic [VAL_W-1:0]           val,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_queue: DEPTH must be a power of two, >= 2");
    end

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push, pop;
    ir_fields_t         head_fields;

    // in_ready looks only at registered count: no out_ready-to-in_ready path.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= instr;
        end
    end

    ir_field_decode #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .VAL_W   (VAL_W),
        .NUM_OPS (NUM_OPS)
    ) u_decode (
        .instr   (mem_q[rd_ptr_q]),
        .valid   (out_valid),
        .fields  (head_fields),
        .illegal (illegal)
    );

    assign op_code = head_fields.op_code[OPC_W-1:0];
    assign reg_s   = head_fields.reg_s;
    assign acc_s   = head_fields.acc_s;
    assign val     = head_fields.val[VAL_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ============================================================================
//  Module   : tb_instr_queue
//  Purpose  : Directed table-driven bench for instr_queue (default parameters).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op_code;
    logic        reg_s;
    logic        acc_s;
    logic [7:0]  val;
    logic [2:0]  count;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IR_ILLEGAL_CHK_EN
    localparam bit ILL_ON = 1'b1;
`else
    localparam bit ILL_ON = 1'b0;
`endif

    instr_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_code   (op_code),
        .reg_s     (reg_s),
        .acc_s     (acc_s),
        .val       (val),
        .count     (count),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] ins;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [2:0]  e_cnt;
        logic [15:0] e_head;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [15:0] ins, logic fl, logic ordy,
                                logic e_ov, logic e_ir, logic [2:0] e_cnt,
                                logic [15:0] e_head);
        vec_t v;
        v.iv = iv; v.ins = ins; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_head = e_head;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a given head word (zeros when empty).
    task automatic check_outputs(string tag, logic e_ov, logic e_ir,
                                 logic [2:0] e_cnt, logic [15:0] e_head);
        logic [15:0] h;
        logic        e_ill;
        h     = e_ov ? e_head : 16'h0000;
        e_ill = ILL_ON && e_ov && (h[15:10] >= 6'd40);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        check({tag, ".count"},     32'(count),     32'(e_cnt));
        check({tag, ".op_code"},   32'(op_code),   32'(h[15:10]));
        check({tag, ".reg_s"},     32'(reg_s),     32'(h[9]));
        check({tag, ".acc_s"},     32'(acc_s),     32'(h[8]));
        check({tag, ".val"},       32'(val),       32'(h[7:0]));
        check({tag, ".illegal"},   32'(illegal),   32'(e_ill));
    endtask

    task automatic drive(logic iv, logic [15:0] ins, logic fl, logic ordy);
        in_valid  = iv;
        instr     = ins;
        flush     = fl;
        out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        //                iv    instr     fl    ordy  ov    ir    cnt   head
        vecs.push_back(mk(1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 16'hA5C3));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000));
        // fill with decoder stalled; fifth word waits for a pop
        vecs.push_back(mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1234));
        vecs.push_back(mk(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h1234));
        vecs.push_back(mk(1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234));
        vecs.push_back(mk(1'b1, 16'hDEF0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b1, 16'h0F11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b1, 16'h0F11, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h5678));
        vecs.push_back(mk(1'b1, 16'h0F11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h5678));
        // full, both sides streaming for 8 cycles across pointer wrap
        vecs.push_back(mk(1'b1, 16'h2D22, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h9ABC));
        vecs.push_back(mk(1'b1, 16'h2D22, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'hDEF0));
        vecs.push_back(mk(1'b1, 16'h4466, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h0F11));
        vecs.push_back(mk(1'b1, 16'h7B99, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h2D22));
        vecs.push_back(mk(1'b1, 16'hC3AA, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h4466));
        vecs.push_back(mk(1'b1, 16'h3C0F, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h7B99));
        vecs.push_back(mk(1'b1, 16'h8181, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'hC3AA));
        vecs.push_back(mk(1'b1, 16'h6E5A, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 16'h3C0F));
        // flush at count 3 with concurrent push and pop
        vecs.push_back(mk(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000));
        // opcode 40 then 39
        vecs.push_back(mk(1'b1, 16'hA000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'hA000));
        vecs.push_back(mk(1'b1, 16'h9C55, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 16'h9C55));
        vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000));

        #1;
        check_outputs("reset", 1'b0, 1'b1, 3'd0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hand-checked decode of the first instruction.
        drive(1'b1, 16'hA5C3, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("first.op_code", 32'(op_code), 32'h29);
        check("first.reg_s",   32'(reg_s),   32'd0);
        check("first.acc_s",   32'(acc_s),   32'd1);
        check("first.val",     32'(val),     32'hC3);
        check("first.out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("first.drain", 32'(out_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].ins, vecs[i].fl, vecs[i].ordy);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                          vecs[i].e_cnt, vecs[i].e_head);
        end

        // Asynchronous reset with two entries queued.
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 16'h5678, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("pre_rst", 1'b1, 1'b1, 3'd2, 16'h1234);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 1'b1, 3'd0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h9ABC, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("post_rst", 1'b1, 1'b1, 3'd1, 16'h9ABC);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_outputs("post_rst_drain", 1'b0, 1'b1, 3'd0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction register with a DEPTH-entry prefetch queue. It sits between instruction fetch and the decoder and splits each buffered instruction into opcode, register-select, accumulator-select and immediate fields. Fetch and decode are decoupled with valid/ready handshakes, and a synchronous flush supports branches.

## Interface
- INSTR_W, 16: instruction width; must equal OPC_W+2+VAL_W
- OPC_W, 6: opcode field width
- VAL_W, 8: immediate field width
- DEPTH, 4: queue entries; power of two, ≥2
- NUM_OPS, 40: count of legal opcodes (used only with IR_ILLEGAL_CHK_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instr
- in_ready  out  1  queue can accept
- instr  in  INSTR_W  instruction word
- flush  in  1  synchronous discard of all entries
- out_valid  out  1  head entry available
- out_ready  in  1  decoder accepts head
- op_code  out  OPC_W  instr[INSTR_W-1 -: OPC_W] of head
- reg_s  out  1  instr[VAL_W+1] of head
- acc_s  out  1  instr[VAL_W] of head
- val  out  VAL_W  instr[VAL_W-1:0] of head
- count  out  $clog2(DEPTH+1)  occupied entries
- illegal  out  1  head opcode ≥ NUM_OPS (0 when macro off)

## Operation
- Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus count. Pointers wrap DEPTH-1→0 naturally.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready. A full queue does not accept a push, even in a cycle that pops.
- out_valid = (count != 0).
- Fields decode from mem[rd_ptr] when out_valid=1. All field outputs and illegal are 0 when out_valid=0.
- Simultaneous push and pop (non-empty, non-full): count unchanged, both pointers advance.
- Flush dominates everything in the same cycle. Next state: count=0, wr_ptr=rd_ptr=0, and any concurrent push or pop is discarded.
- Memory contents are not reset; only pointers and count are.
- Reset (async assert, any time): count=0, pointers=0, in_ready=1, out_valid=0, all fields 0, illegal=0. Reset during a transfer loses all entries.

## Timing
- Latency: an instruction pushed at edge N is visible on outputs after edge N (cycle N+1) when the queue was empty. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained when 0<count<DEPTH.
- A decoder holding out_ready=0 keeps the head stable. Outputs are unchanged until pop.
- in_ready drops the cycle after the DEPTH-th push and rises the cycle after the next pop.
- out_valid drops the cycle after the final pop, or the cycle after flush.

## Configuration
- IR_ILLEGAL_CHK_EN defined: illegal = out_valid & (op_code ≥ NUM_OPS). The comparator is compiled in. Illegal instructions are still queued and popped normally; flagging is informational only.
- IR_ILLEGAL_CHK_EN undefined: illegal is tied to 0 and NUM_OPS is unused.

## Structure
- Shared package ir_pkg holds:
  - default widths INSTR_W/OPC_W/VAL_W
  - field-offset localparams
  - an ir_fields_t packed struct {op_code, reg_s, acc_s, val}, reused by the decoder
- One natural sub-module: ir_field_decode, combinational, instr word → ir_fields_t plus illegal check. It is instantiated once on the head entry.
- Elaboration-time assertions: INSTR_W == OPC_W+2+VAL_W, and DEPTH a power of two.

## Test plan
- Reset then single push of 16'hA5C3 with out_ready=1. Next cycle: out_valid=1, op_code=6'h29, reg_s=0, acc_s=1, val=8'hC3. The cycle after that, out_valid=0.
- Push 5 words with out_ready=0, DEPTH=4. Result: 4 accepted, in_ready=0 after the 4th, count=4, and the 5th is held by fetch until one pop.
- Full queue with in_valid=1 and out_ready=1 for 8 cycles. Entries drain and refill in FIFO order across pointer wrap, with no loss or duplication.
- count=3, flush asserted together with in_valid=1 and out_ready=1. Next cycle: count=0, out_valid=0, fields 0, and the pushed word is discarded.
- With IR_ILLEGAL_CHK_EN and NUM_OPS=40, push opcode 6'd40 then 6'd39. Result: illegal=1 for the first head and 0 for the second. Without the macro, illegal=0 for both.
- Assert rst mid-stream with count=2. Immediately: out_valid=0, in_ready=1, count=0. After release, the first new push appears one cycle later.
